muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_ctrl.sv | 127 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encoding and FSM state types for the HI/LO multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MULT  = 2'b10,
        OP_DIV   = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[0];
    endfunction

    function automatic logic op_is_signed(input muldiv_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: shift-add multiply or restoring-divide step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           fits;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits}, shifted left each step.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = rem_sh - {1'b0, opnd};
        fits     = (rem_sh >= {1'b0, opnd});
        acc_next = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            // A zero divisor always fits, giving an all-ones quotient and the dividend as remainder.
            if (fits) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative HI/LO multiply/divide controller; MULDIV_SIGNED_EN enables MULT/DIV sign handling
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             rd_req,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef MULDIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    muldiv_state_e       state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]    opnd_q;
    logic                is_div_q;
    logic                neg_q;
    logic                rem_neg_q;

    logic                signed_op;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic [2*WIDTH-1:0]  acc_next;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quo_fix;
    logic [WIDTH-1:0]    rem_fix;
    logic [WIDTH-1:0]    fix_hi;
    logic [WIDTH-1:0]    fix_lo;

    // The datapath always works on magnitudes; sign is restored in FIX.
    always_comb begin
        signed_op = SIGNED_EN & op_is_signed(muldiv_op_e'(op));
        a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_next)
    );

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fix_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_comb begin
        busy  = (state_q != ST_IDLE);
        stall = busy && (start || rd_req || (hilo_we != 2'b00));
        done  = (state_q == ST_FIX) && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hilo_we[1]) hi <= hilo_wdata;
                    if (hilo_we[0]) lo <= hilo_wdata;
                    if (start && !flush) begin
                        state_q   <= ST_RUN;
                        cnt_q     <= '0;
                        acc_q     <= {{WIDTH{1'b0}}, a_mag};
                        opnd_q    <= b_mag;
                        is_div_q  <= op_is_div(muldiv_op_e'(op));
                        neg_q     <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rem_neg_q <= signed_op & a[WIDTH-1];
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    if (!flush) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl (results popped and compared on done)
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         rd_req;
    logic [1:0]   hilo_we;
    logic [W-1:0] hilo_wdata;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .rd_req     (rd_req),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic         s;
        logic [W-1:0] ax, ay, q, r;
        s = SIGNED_EN && o[1];
        if (!o[0]) begin
            if (s) return {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
            return {{W{1'b0}}, x} * {{W{1'b0}}, y};
        end
        ax = (s && x[W-1]) ? -x : x;
        ay = (s && y[W-1]) ? -y : y;
        if (ay == '0) begin
            q = '1;
            r = ax;
        end else begin
            q = ax / ay;
            r = ax % ay;
        end
        if (s && (x[W-1] ^ y[W-1])) q = -q;
        if (s && x[W-1]) r = -r;
        return {r, q};
    endfunction

    // Scoreboard: every done pulse pops one expected {hi,lo} and checks it after the write edge.
    always @(negedge clk) begin
        #2;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=%b with no operation expected", done);
            end else begin
                mon_exp = exp_q.pop_front();
                @(posedge clk);
                #1;
                checks++;
                if ({hi, lo} !== mon_exp) begin
                    errors++;
                    $display("FAIL result: hi=%h lo=%h expected hi=%h lo=%h", hi, lo, mon_exp[2*W-1:W], mon_exp[W-1:0]);
                end
            end
        end
    end

    task automatic issue(input bit push, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) exp_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 1;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic set_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
        @(negedge clk);
        hilo_we = 2'b10; hilo_wdata = h;
        @(negedge clk);
        hilo_we = 2'b01; hilo_wdata = l;
        @(negedge clk);
        hilo_we = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== '0)      begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== '0)      begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        rst = 1'b0;
    endtask

    task automatic test_multu();
        int k;
        issue(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(k);
        checks++; if (k !== W + 1) begin errors++; $display("FAIL multu_latency: got %0d want %0d", k, W + 1); end
        @(posedge clk); #2;
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    endtask

    task automatic test_divu();
        logic [W-1:0] xs[8];
        logic [W-1:0] ys[8];
        int k;
        xs = '{32'd100, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'd0, $urandom, $urandom};
        ys = '{32'd7, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd100, 32'd9, $urandom_range(1, 1000), $urandom};
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, OP_DIVU, xs[i], ys[i]);
            wait_done(k);
            checks++; if (k !== W + 1) begin errors++; $display("FAIL divu_latency[%0d]: got %0d want %0d", i, k, W + 1); end
            @(posedge clk); #2;
            if (i == 0) begin
                checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7: hi=%0d lo=%0d want hi=2 lo=14", hi, lo); end
            end
            if (i == 1) begin
                checks++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_by_zero: hi=%h lo=%h want hi=5 lo=ffffffff", hi, lo); end
            end
        end
    endtask

    task automatic test_signed_ops();
        logic [W-1:0] eh_div, el_div, eh_mul, el_mul;
        int k;
`ifdef MULDIV_SIGNED_EN
        eh_div = 32'hFFFF_FFFF; el_div = 32'hFFFF_FFFD;
        eh_mul = 32'hFFFF_FFFF; el_mul = 32'hFFFF_FFF4;
`else
        eh_div = 32'd1;         el_div = 32'h7FFF_FFFC;
        eh_mul = 32'd3;         el_mul = 32'hFFFF_FFF4;
`endif
        issue(1'b1, OP_DIV, -32'sd7, 32'd2);
        wait_done(k);
        @(posedge clk); #2;
        checks++; if ({hi, lo} !== {eh_div, el_div}) begin errors++; $display("FAIL div_m7_2: hi=%h lo=%h want hi=%h lo=%h", hi, lo, eh_div, el_div); end
        issue(1'b1, OP_MULT, -32'sd3, 32'd4);
        wait_done(k);
        @(posedge clk); #2;
        checks++; if ({hi, lo} !== {eh_mul, el_mul}) begin errors++; $display("FAIL mult_m3_4: hi=%h lo=%h want hi=%h lo=%h", hi, lo, eh_mul, el_mul); end
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, (i % 2 == 0) ? OP_MULT : OP_DIV, $urandom, $urandom_range(1, 32'h7FFF) | ((i > 2) ? 32'h8000_0000 : 32'h0));
            wait_done(k);
            checks++; if (k !== W + 1) begin errors++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, k, W + 1); end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_hilo_write();
        @(negedge clk);
        hilo_we = 2'b01; hilo_wdata = 32'h0000_1234;
        @(negedge clk);
        hilo_we = 2'b10; hilo_wdata = 32'h0000_5678;
        checks++; if (lo !== 32'h0000_1234) begin errors++; $display("FAIL mtlo: got %h want 00001234", lo); end
        @(negedge clk);
        hilo_we = 2'b00;
        checks++; if ({hi, lo} !== {32'h0000_5678, 32'h0000_1234}) begin errors++; $display("FAIL mthi: hi=%h lo=%h want 00005678 00001234", hi, lo); end
    endtask

    task automatic test_stall_rd_req();
        set_hilo(32'h0, 32'h0000_1234);
        issue(1'b1, OP_MULTU, 32'd2, 32'd3);
        for (int i = 2; i <= W + 1; i++) begin
            @(negedge clk);
            start  = (i == 5);
            a      = 32'd7;
            b      = 32'd9;
            rd_req = (i >= 10);
            #1;
            checks++;
            if (stall !== ((i == 5) || (i >= 10))) begin
                errors++; $display("FAIL stall[%0d]: got %b want %b", i, stall, (i == 5) || (i >= 10));
            end
        end
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done_cycle: done=%b want 1", done); end
        @(posedge clk); #2;
        checks++; if ({hi, lo} !== {32'd0, 32'd6}) begin errors++; $display("FAIL stall_result: hi=%h lo=%h want 0 6", hi, lo); end
        @(negedge clk); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b want 0", stall); end
        rd_req = 1'b0;
    endtask

    task automatic test_flush();
        set_hilo(32'hAAAA_5555, 32'h5555_AAAA);
        issue(1'b0, OP_DIVU, 32'd1000, 32'd3);
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            hilo_we    = (i == 5) ? 2'b11 : 2'b00;
            hilo_wdata = 32'hDEAD_BEEF;
            flush      = (i == 12);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        checks++; if ({hi, lo} !== {32'hAAAA_5555, 32'h5555_AAAA}) begin errors++; $display("FAIL flush_hilo: hi=%h lo=%h want aaaa5555 5555aaaa", hi, lo); end
        issue(1'b0, OP_MULTU, 32'd3, 32'd5);
        for (int i = 2; i <= W + 1; i++) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_fix_done: got %b want 0", done); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_fix_busy: got %b want 0", busy); end
        checks++; if ({hi, lo} !== {32'hAAAA_5555, 32'h5555_AAAA}) begin errors++; $display("FAIL flush_fix_hilo: hi=%h lo=%h want aaaa5555 5555aaaa", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int k;
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'd11; b = 32'd13;
        hilo_we = 2'b10; hilo_wdata = 32'hCAFE_F00D;
        exp_q.push_back(model(OP_MULTU, 32'd11, 32'd13));
        @(negedge clk);
        start = 1'b0; hilo_we = 2'b00;
        checks++; if (hi !== 32'hCAFE_F00D) begin errors++; $display("FAIL we_with_start_hi: got %h want cafef00d", hi); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL we_with_start_busy: got %b want 1", busy); end
        wait_done(k);
        checks++; if (k !== W + 1) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", k, W + 1); end
        issue(1'b1, OP_DIVU, 32'd1000, 32'd7);
        wait_done(k);
        checks++; if (k !== W + 1) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", k, W + 1); end
        @(posedge clk); #2;
    endtask

    task automatic test_rst_mid();
        int k;
        issue(1'b0, OP_MULTU, 32'd9, 32'd9);
        repeat (8) @(negedge clk);
        rd_req = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_rst_stall: got %b want 1", stall); end
        rst = 1'b1;
        #1;
        checks++; if ({busy, stall, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: busy/stall/done=%b want 000", {busy, stall, done}); end
        checks++; if ({hi, lo} !== '0) begin errors++; $display("FAIL rst_mid_hilo: hi=%h lo=%h want 0 0", hi, lo); end
        @(negedge clk);
        rst = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_discard: busy=%b want 0", busy); end
        issue(1'b1, OP_MULTU, 32'd6, 32'd7);
        wait_done(k);
        checks++; if (k !== W + 1) begin errors++; $display("FAIL post_rst_latency: got %0d want %0d", k, W + 1); end
        @(posedge clk); #2;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        flush = 1'b0; rd_req = 1'b0; hilo_we = 2'b00; hilo_wdata = '0;
        test_reset();
        test_multu();
        test_divu();
        test_signed_ops();
        test_hilo_write();
        test_stall_rd_req();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d results outstanding, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
